axi_responder: RTL and testbench
================================

Name: axi_responder

Overview:
- AXI3/AXI4-style memory responder (slave) for the AXI master interface driven by the axis streaming DMA block.
- Terminates the AW/W/B write channels and the AR/R read channels.
- Backs them with an internal word-addressed RAM so that write-then-read-back works.
- Used as the memory-side endpoint in simulation and as an on-chip BRAM scratchpad target in the PL.

Parameters:
- AXI_ID_WIDTH, 8, width of awid/bid/arid/rid.
- AXI_LEN_WIDTH, 8, width of awlen/arlen; beats = len+1.
- AXI_ADDR_WIDTH, 32, byte address width.
- AXI_DATA_WIDTH, 256, data bus width; power of two, 8..1024.
- MEM_AWIDTH, 10, log2 of RAM depth in AXI_DATA_WIDTH-bit words.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- axi_awid  in  AXI_ID_WIDTH  write ID
- axi_awaddr  in  AXI_ADDR_WIDTH  write start byte address
- axi_awlen  in  AXI_LEN_WIDTH  write beats-1
- axi_awvalid  in  1  / axi_awready  out  1  AW handshake
- axi_wdata  in  AXI_DATA_WIDTH  write data
- axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- axi_wlast  in  1  last write beat
- axi_wvalid  in  1  / axi_wready  out  1  W handshake
- axi_bid  out  AXI_ID_WIDTH  / axi_bresp  out  2  write response
- axi_bvalid  out  1  / axi_bready  in  1  B handshake
- axi_arid  in  AXI_ID_WIDTH  / axi_araddr  in  AXI_ADDR_WIDTH  / axi_arlen  in  AXI_LEN_WIDTH  read request
- axi_arvalid  in  1  / axi_arready  out  1  AR handshake
- axi_rid  out  AXI_ID_WIDTH  / axi_rdata  out  AXI_DATA_WIDTH  / axi_rresp  out  2  / axi_rlast  out  1  read data
- axi_rvalid  out  1  / axi_rready  in  1  R handshake

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - awready, wready, bvalid, arready, rvalid and rlast are 0 while rst is high.
  - bid, bresp, rid, rresp = 0.
  - RAM contents are not reset.
- Address mapping:
  - word = addr >> log2(AXI_DATA_WIDTH/8), truncated to MEM_AWIDTH bits.
  - The word increments by 1 per beat (INCR burst only; awburst/arburst/awsize are not inputs).
  - The word wraps modulo 2^MEM_AWIDTH.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid&&awready, capture awid, word and beat count (awlen+1), then go to W_DATA. wready rises the next cycle.
  - W_DATA: wready=1. Each wvalid&&wready writes wdata to RAM[word] under wstrb byte enables, increments word and decrements the count.
  - On the beat where count==1, go to W_RESP.
  - bresp=SLVERR(2'b10) if wlast was seen on any earlier beat or is absent on the final beat; otherwise OKAY(2'b00).
  - W_RESP: bvalid=1, bid=captured awid, held stable until bready. On bvalid&&bready go to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On handshake, capture arid and count, read RAM[word(araddr)] into the rdata register, and go to R_DATA. rvalid=1 the next cycle (1-cycle latency).
  - R_DATA: rid=captured arid, rresp=OKAY, rlast=1 when count==1.
  - On rvalid&&rready with count>1: register RAM[word+1] the same cycle, so there is no bubble between beats.
  - On the last handshake, clear rvalid/rlast and go to R_IDLE.
  - rvalid&&!rready: rdata, rlast and rid are held stable.
- Write and read FSMs are independent and may run concurrently.
- Same-word write and read in one cycle: the read returns old data (read-before-write).
- rst asserted mid-burst: both FSMs go to idle and all valids drop on the next edge. The in-flight burst is abandoned with no B/R completion; RAM keeps any beats already written.

Decomposition:
- Shared header axi_defs.vh, include-guarded, holding:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - burst encodings
  - the byte-count-to-AxSIZE mapping already used on the master side
  - a clog2 function
- One sub-module, axi_responder_ram: simple dual-port RAM with one write port carrying byte enables and one registered read port, with read-before-write behaviour.

Test Plan:
- Single-beat write then read: AW addr 0x40, len 0, wdata 0xA5..A5, wstrb all ones, wlast=1.
  - Required: bvalid one cycle after the W beat, bresp=00.
  - AR addr 0x40, len 0: rvalid one cycle after AR, rdata 0xA5..A5, rlast=1.
- 16-beat burst: AW len 15, awid 0x3C, data = beat index; then AR len 15 with rready toggling 1/0.
  - Required: 16 R beats with data 0..15, rlast only on beat 16, rid=0x3C when arid=0x3C, bid=0x3C.
  - rdata held while rready=0.
- Byte strobes: preload word 0x20 with all 0xFF bytes, write with wstrb=0x0000000F and wdata=0.
  - Required: readback has the low 4 bytes 0x00 and the rest 0xFF.
- wlast protocol error: len 3 with wlast asserted on beat 2.
  - Required: 4 beats still accepted, then bresp=10.
- Wrap and backpressure:
  - MEM_AWIDTH=4, write len 3 starting at word 14; read words 14,15,0,1 and data matches.
  - Hold bready=0 for 10 cycles: bvalid stays 1, awready stays 0.
- Reset mid-burst: assert rst during beat 3 of an 8-beat read.
  - Required: rvalid=0 the next cycle, arready=1 after release, and a new read returns correct data.

Source files
------------

// File: rtl/axi_responder_pkg.sv
// Shared AXI definitions for the responder: response/burst codes, size mapping,
// FSM state types and a clog2 helper usable in constant expressions.
package axi_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // AxSIZE encoding for a beat of the given byte count, as used by the master side.
   function automatic logic [2:0] bytes_to_size(input int nbytes);
      return 3'(clog2(nbytes));
   endfunction

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/axi_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port that
// returns the old contents when the same word is written in the same cycle.
module axi_responder_ram #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    wr_en_i,
   input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
   input  logic                    rd_en_i,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
         if (wr_en_i && wr_strb_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_responder.sv
// AXI memory responder: independent INCR write and read engines in front of a
// word-addressed RAM; bursts wrap modulo the RAM depth.
module axi_responder
   import axi_responder_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int MEM_AWIDTH     = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
   input  logic [AXI_LEN_WIDTH-1:0]    axi_awlen,
   input  logic                        axi_awvalid,
   output logic                        axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                        axi_wlast,
   input  logic                        axi_wvalid,
   output logic                        axi_wready,
   output logic [AXI_ID_WIDTH-1:0]     axi_bid,
   output logic [1:0]                  axi_bresp,
   output logic                        axi_bvalid,
   input  logic                        axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
   input  logic [AXI_LEN_WIDTH-1:0]    axi_arlen,
   input  logic                        axi_arvalid,
   output logic                        axi_arready,
   output logic [AXI_ID_WIDTH-1:0]     axi_rid,
   output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
   output logic [1:0]                  axi_rresp,
   output logic                        axi_rlast,
   output logic                        axi_rvalid,
   input  logic                        axi_rready
);

   localparam int BYTE_SH = clog2(AXI_DATA_WIDTH/8);
   localparam int CW      = AXI_LEN_WIDTH + 1;
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]         CNT_TWO  = CW'(2);
   localparam logic [MEM_AWIDTH-1:0] WORD_ONE = MEM_AWIDTH'(1);

   wr_state_e               wr_st_q;
   logic                    awready_q, wready_q, bvalid_q, werr_q;
   logic [AXI_ID_WIDTH-1:0] bid_q;
   logic [1:0]              bresp_q;
   logic [MEM_AWIDTH-1:0]   wword_q;
   logic [CW-1:0]           wcnt_q;

   rd_state_e               rd_st_q;
   logic                    arready_q, rvalid_q, rlast_q;
   logic [AXI_ID_WIDTH-1:0] rid_q;
   logic [MEM_AWIDTH-1:0]   rword_q;
   logic [CW-1:0]           rcnt_q;

   logic [MEM_AWIDTH-1:0] aw_word, ar_word, ram_raddr;
   logic                  w_fire, ar_fire, r_fire, ram_re;
   logic                  unused_addr_bits;

   assign aw_word = axi_awaddr[BYTE_SH +: MEM_AWIDTH];
   assign ar_word = axi_araddr[BYTE_SH +: MEM_AWIDTH];
   assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

   assign w_fire  = (wr_st_q == W_DATA) && axi_wvalid && wready_q;
   assign ar_fire = (rd_st_q == R_IDLE) && axi_arvalid && arready_q;
   assign r_fire  = (rd_st_q == R_DATA) && rvalid_q && axi_rready;

   // rword_q already points at the next beat, so a consumed beat refills rdata without a bubble.
   assign ram_re    = ar_fire || (r_fire && (rcnt_q != CNT_ONE));
   assign ram_raddr = (rd_st_q == R_IDLE) ? ar_word : rword_q;

   axi_responder_ram #(
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .ADDR_WIDTH (MEM_AWIDTH)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (w_fire),
      .wr_addr_i (wword_q),
      .wr_data_i (axi_wdata),
      .wr_strb_i (axi_wstrb),
      .rd_en_i   (ram_re),
      .rd_addr_i (ram_raddr),
      .rd_data_o (axi_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_st_q   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         werr_q    <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= RESP_OKAY;
         wword_q   <= '0;
         wcnt_q    <= '0;
      end else begin
         case (wr_st_q)
            W_IDLE: begin
               if (axi_awvalid && awready_q) begin
                  bid_q     <= axi_awid;
                  wword_q   <= aw_word;
                  wcnt_q    <= CW'(axi_awlen) + CNT_ONE;
                  werr_q    <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wr_st_q   <= W_DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  wword_q <= wword_q + WORD_ONE;
                  wcnt_q  <= wcnt_q - CNT_ONE;
                  if (wcnt_q == CNT_ONE) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (werr_q || !axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                     wr_st_q  <= W_RESP;
                  end else if (axi_wlast) begin
                     werr_q <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (axi_bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wr_st_q   <= W_IDLE;
               end
            end
            default: wr_st_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_st_q   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rword_q   <= '0;
         rcnt_q    <= '0;
      end else begin
         case (rd_st_q)
            R_IDLE: begin
               if (ar_fire) begin
                  rid_q     <= axi_arid;
                  rcnt_q    <= CW'(axi_arlen) + CNT_ONE;
                  rword_q   <= ar_word + WORD_ONE;
                  rlast_q   <= (axi_arlen == '0);
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rd_st_q   <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (rcnt_q == CNT_ONE) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rd_st_q   <= R_IDLE;
                  end else begin
                     rcnt_q  <= rcnt_q - CNT_ONE;
                     rlast_q <= (rcnt_q == CNT_TWO);
                     rword_q <= rword_q + WORD_ONE;
                  end
               end
            end
            default: rd_st_q <= R_IDLE;
         endcase
      end
   end

   assign axi_awready = awready_q;
   assign axi_wready  = wready_q;
   assign axi_bvalid  = bvalid_q;
   assign axi_bid     = bid_q;
   assign axi_bresp   = bresp_q;
   assign axi_arready = arready_q;
   assign axi_rvalid  = rvalid_q;
   assign axi_rlast   = rlast_q;
   assign axi_rid     = rid_q;
   assign axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_responder.sv
// Randomized bench for axi_responder against a word-array memory model.
module tb_axi_responder;

   localparam int MAW = 4;
   localparam int NW  = 1 << MAW;

   logic         clk, rst;
   logic [7:0]   axi_awid, axi_bid, axi_arid, axi_rid;
   logic [31:0]  axi_awaddr, axi_araddr;
   logic [7:0]   axi_awlen, axi_arlen;
   logic         axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
   logic [255:0] axi_wdata, axi_rdata;
   logic [31:0]  axi_wstrb;
   logic [1:0]   axi_bresp, axi_rresp;
   logic         axi_bvalid, axi_bready, axi_arvalid, axi_arready;
   logic         axi_rlast, axi_rvalid, axi_rready;

   axi_responder #(
      .AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32),
      .AXI_DATA_WIDTH(256), .MEM_AWIDTH(MAW)
   ) dut (
      .clk(clk), .rst(rst),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [255:0] model [NW];
   logic [255:0] wq [$];
   logic [31:0]  sq [$];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      return int'(addr >> 5) % NW;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beats come from wq/sq; wlast sits on beat last_at (-1 = the proper final beat).
   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int last_at, input int bhold, input int gaps);
      int word, to, lpos;
      logic [255:0] d;
      logic [31:0] s;
      lpos = (last_at < 0) ? len : last_at;
      axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len); axi_awvalid = 1'b1;
      to = 0;
      while (!axi_awready && to < 100) begin tick(); to++; end
      chk("aw_wait", 256'(to < 100), 256'(1));
      tick();
      axi_awvalid = 1'b0;
      word = word_of(addr);
      for (int i = 0; i <= len; i++) begin
         if (gaps != 0 && $urandom_range(0, 2) == 0) begin axi_wvalid = 1'b0; tick(); end
         d = wq[i]; s = sq[i];
         axi_wdata = d; axi_wstrb = s; axi_wlast = (i == lpos); axi_wvalid = 1'b1;
         to = 0;
         while (!axi_wready && to < 100) begin tick(); to++; end
         chk("w_wait", 256'(to < 100), 256'(1));
         tick();
         for (int b = 0; b < 32; b++) if (s[b]) model[word][b*8 +: 8] = d[b*8 +: 8];
         word = (word + 1) % NW;
      end
      axi_wvalid = 1'b0; axi_wlast = 1'b0;
      chk("bvalid", 256'(axi_bvalid), 256'(1));
      chk("bresp", 256'(axi_bresp), (lpos != len) ? 256'(2) : 256'(0));
      chk("bid", 256'(axi_bid), 256'(id));
      for (int k = 0; k < bhold; k++) begin
         tick();
         chk("bvalid_hold", 256'(axi_bvalid), 256'(1));
         chk("awready_hold", 256'(axi_awready), 256'(0));
      end
      axi_bready = 1'b1;
      tick();
      axi_bready = 1'b0;
      chk("bvalid_clr", 256'(axi_bvalid), 256'(0));
   endtask

   // mode: 0 rready high, 1 toggling 1/0, 2 random. abort_at>=0 stops before that beat.
   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int mode, input int abort_at, output logic [255:0] last_d);
      int word, to, i;
      logic rr, hl;
      logic [255:0] held;
      last_d = '0;
      axi_arid = id; axi_araddr = addr; axi_arlen = 8'(len); axi_arvalid = 1'b1;
      to = 0;
      while (!axi_arready && to < 100) begin tick(); to++; end
      chk("ar_wait", 256'(to < 100), 256'(1));
      tick();
      axi_arvalid = 1'b0;
      chk("rvalid_lat", 256'(axi_rvalid), 256'(1));
      word = word_of(addr); i = 0; to = 0;
      while (i <= len && to < 500) begin
         if (i == abort_at) break;
         to++;
         case (mode)
            0:       rr = 1'b1;
            1:       rr = (to % 2 == 1);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         axi_rready = rr;
         if (rr) begin
            chk("rvalid", 256'(axi_rvalid), 256'(1));
            chk("rdata", axi_rdata, model[word]);
            chk("rlast", 256'(axi_rlast), 256'(i == len));
            chk("rid", 256'(axi_rid), 256'(id));
            last_d = axi_rdata;
            i++;
            word = (word + 1) % NW;
         end else begin
            held = axi_rdata; hl = axi_rlast;
         end
         tick();
         if (!rr) begin
            chk("rdata_hold", axi_rdata, held);
            chk("rlast_hold", 256'(axi_rlast), 256'(hl));
            chk("rvalid_hold", 256'(axi_rvalid), 256'(1));
         end
      end
      axi_rready = 1'b0;
      if (abort_at < 0) begin
         chk("r_beats", 256'(i), 256'(len + 1));
         chk("rvalid_end", 256'(axi_rvalid), 256'(0));
      end
   endtask

   initial begin
      logic [255:0] rd;
      int len, last_at;
      logic [31:0] addr;
      rst = 1'b1;
      axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
      axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
      axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
      repeat (3) tick();
      chk("rst_awready", 256'(axi_awready), 256'(0));
      chk("rst_wready", 256'(axi_wready), 256'(0));
      chk("rst_bvalid", 256'(axi_bvalid), 256'(0));
      chk("rst_arready", 256'(axi_arready), 256'(0));
      chk("rst_rvalid", 256'(axi_rvalid), 256'(0));
      chk("rst_rlast", 256'(axi_rlast), 256'(0));
      chk("rst_ids", 256'({axi_bid, axi_rid}), 256'(0));
      chk("rst_resp", 256'({axi_bresp, axi_rresp}), 256'(0));
      rst = 1'b0;

      // single beat write / read
      wq.delete(); sq.delete();
      wq.push_back({32{8'hA5}}); sq.push_back(32'hFFFF_FFFF);
      do_write(8'h11, 32'h40, 0, -1, 0, 0);
      do_read(8'h11, 32'h40, 0, 0, -1, rd);
      chk("single_data", rd, {32{8'hA5}});

      // 16-beat burst covering every word, read with toggling rready
      wq.delete(); sq.delete();
      for (int i = 0; i < 16; i++) begin wq.push_back(256'(i)); sq.push_back(32'hFFFF_FFFF); end
      do_write(8'h3C, 32'h0, 15, -1, 0, 0);
      do_read(8'h3C, 32'h0, 15, 1, -1, rd);
      chk("burst_last", rd, 256'(15));

      // byte strobes (word 0x20 wraps onto word 0 with a 16-word RAM)
      wq.delete(); sq.delete();
      wq.push_back({32{8'hFF}}); sq.push_back(32'hFFFF_FFFF);
      do_write(8'h01, 32'h20 << 5, 0, -1, 0, 0);
      wq.delete(); sq.delete();
      wq.push_back('0); sq.push_back(32'h0000_000F);
      do_write(8'h02, 32'h20 << 5, 0, -1, 0, 0);
      do_read(8'h03, 32'h20 << 5, 0, 0, -1, rd);
      chk("strb_data", rd, {{28{8'hFF}}, 32'h0});

      // wlast on beat 2 of 4
      wq.delete(); sq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back(rnd256()); sq.push_back(32'hFFFF_FFFF); end
      do_write(8'h44, 32'h80, 3, 1, 0, 0);
      do_read(8'h45, 32'h80, 3, 0, -1, rd);

      // wrap 14,15,0,1 with B backpressure
      wq.delete(); sq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back(rnd256()); sq.push_back(32'hFFFF_FFFF); end
      do_write(8'h55, 32'd14 << 5, 3, -1, 10, 0);
      do_read(8'h56, 32'd14 << 5, 3, 2, -1, rd);

      // reset during beat 3 of an 8-beat read
      do_read(8'h66, 32'h0, 7, 0, 2, rd);
      rst = 1'b1;
      tick();
      chk("rst_mid_rvalid", 256'(axi_rvalid), 256'(0));
      chk("rst_mid_rlast", 256'(axi_rlast), 256'(0));
      rst = 1'b0;
      tick();
      chk("rst_rel_arready", 256'(axi_arready), 256'(1));
      do_read(8'h67, 32'h0, 7, 0, -1, rd);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         len  = $urandom_range(0, 7);
         addr = $urandom;
         last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         wq.delete(); sq.delete();
         for (int i = 0; i <= len; i++) begin
            wq.push_back(rnd256());
            sq.push_back(($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
         end
         do_write(8'($urandom), addr, len, last_at, $urandom_range(0, 3), 1);
         do_read(8'($urandom), addr, len, 2, -1, rd);
         do_read(8'($urandom), $urandom, $urandom_range(0, 15), $urandom_range(0, 2), -1, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
